// File: rtl/serial_inc_controller.sv
// Serial N-bit incrementer controller: steps one external 2-bit increment slice across the operand, two bits per clock.
// Optional build macro EARLY_EXIT_EN: finish as soon as a slice produces no carry-out.
module serial_inc_controller #(
   parameter int unsigned N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic         ci,
   output logic [1:0]   slice_a,
   output logic         slice_ci,
   input  logic [1:0]   slice_s,
   input  logic         slice_co,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] s,
   output logic         co
);

   localparam int unsigned SLICES = N / 2;
   localparam int unsigned IDX_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLICES - 1);

   generate
      if ((N < 2) || ((N % 2) != 0)) begin : g_bad_width
         $error("serial_inc_controller: N must be even and >= 2");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [N-1:0]     shift;
   logic [N-1:0]     result;

   logic [N-1:0]     shift_nx;
   logic [N-1:0]     result_nx;
   logic [N+1:0]     result_cat;
   logic             last;
   logic             accept;
`ifdef EARLY_EXIT_EN
   logic [N-1:0]     merged;
   int unsigned      done_bits;
`endif

   // Next shift/result values; processed slices accumulate at the top of result.
   always_comb begin
      shift_nx   = shift >> 2;
      result_cat = {slice_s, result};
      result_nx  = result_cat[N+1:2];
      last       = (idx == LAST_IDX);
      accept     = start && ((state == IDLE) || (state == DONE));
`ifdef EARLY_EXIT_EN
      // Carry died out: untouched upper operand bits pass straight into the sum.
      done_bits  = 2 * (32'(idx) + 32'd1);
      merged     = (shift_nx << done_bits) | (result_nx >> (N - done_bits));
`endif
   end

   // slice_ci doubles as the carry flop; slice_a mirrors shift[1:0] while in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         shift    <= '0;
         result   <= '0;
         slice_a  <= '0;
         slice_ci <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         s        <= '0;
         co       <= 1'b0;
      end else if (accept) begin
         state    <= RUN;
         idx      <= '0;
         shift    <= a;
         result   <= '0;
         slice_a  <= a[1:0];
         slice_ci <= ci;
         busy     <= 1'b1;
         done     <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (last) begin
                  s        <= result_nx;
                  co       <= slice_co;
                  state    <= DONE;
                  idx      <= '0;
                  slice_a  <= '0;
                  slice_ci <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
`ifdef EARLY_EXIT_EN
               else if (!slice_co) begin
                  s        <= merged;
                  co       <= 1'b0;
                  state    <= DONE;
                  idx      <= '0;
                  slice_a  <= '0;
                  slice_ci <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
               end
`endif
               else begin
                  shift    <= shift_nx;
                  result   <= result_nx;
                  idx      <= idx + 1'b1;
                  slice_a  <= shift_nx[1:0];
                  slice_ci <= slice_co;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_inc_controller.sv
// Directed bench for serial_inc_controller (N=8) with a behavioural 2-bit increment slice.
module tb_serial_inc_controller;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic       ci;
   logic [1:0] slice_a;
   logic       slice_ci;
   logic [1:0] slice_s;
   logic       slice_co;
   logic       busy;
   logic       done;
   logic [7:0] s;
   logic       co;
   logic [2:0] slice_sum;

   int checks = 0;
   int errors = 0;

   serial_inc_controller #(.N(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .a        (a),
      .ci       (ci),
      .slice_a  (slice_a),
      .slice_ci (slice_ci),
      .slice_s  (slice_s),
      .slice_co (slice_co),
      .busy     (busy),
      .done     (done),
      .s        (s),
      .co       (co)
   );

   // External shared slice
   assign slice_sum = 3'(slice_a) + 3'(slice_ci);
   assign slice_s   = slice_sum[1:0];
   assign slice_co  = slice_sum[2];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one start for one cycle; returns in the first RUN cycle.
   task automatic start_op(input logic [7:0] av, input logic cv);
      start = 1'b1;
      a     = av;
      ci    = cv;
      tick();
      start = 1'b0;
   endtask

   // lat = number of edges from the accepting edge to the done cycle.
   task automatic wait_done(output int lat, output int busy_cnt);
      lat      = 1;
      busy_cnt = 0;
      while ((done !== 1'b1) && (lat < 30)) begin
         if (busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      a     = 8'h00;
      ci    = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (s !== 8'h00)      begin errors++; $display("FAIL reset_s got %h exp 00", s); end
      checks++; if (co !== 1'b0)      begin errors++; $display("FAIL reset_co got %b exp 0", co); end
      checks++; if (slice_a !== 2'b0) begin errors++; $display("FAIL reset_slice_a got %b exp 00", slice_a); end
      checks++; if (slice_ci !== 1'b0) begin errors++; $display("FAIL reset_slice_ci got %b exp 0", slice_ci); end
   endtask

   task automatic test_increment();
      logic [7:0] va   [4] = '{8'h0F, 8'hFF, 8'h5A, 8'h00};
      logic       vc   [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      logic [7:0] vs   [4] = '{8'h10, 8'h00, 8'h5A, 8'h01};
      logic       vco  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
`ifdef EARLY_EXIT_EN
      int         vlat [4] = '{4, 5, 2, 2};
`else
      int         vlat [4] = '{5, 5, 5, 5};
`endif
      logic [7:0] prev_s;
      int lat, bcnt;
      for (int i = 0; i < 4; i++) begin
         prev_s = s;
         start_op(va[i], vc[i]);
         checks++; if (slice_a !== va[i][1:0]) begin errors++; $display("FAIL inc%0d_slice_a got %b exp %b", i, slice_a, va[i][1:0]); end
         checks++; if (slice_ci !== vc[i]) begin errors++; $display("FAIL inc%0d_slice_ci got %b exp %b", i, slice_ci, vc[i]); end
         checks++; if (s !== prev_s) begin errors++; $display("FAIL inc%0d_s_hold_in_run got %h exp %h", i, s, prev_s); end
         wait_done(lat, bcnt);
         checks++; if (done !== 1'b1) begin errors++; $display("FAIL inc%0d_timeout done=%b", i, done); end
         checks++; if (lat != vlat[i]) begin errors++; $display("FAIL inc%0d_latency got %0d exp %0d", i, lat, vlat[i]); end
         checks++; if (bcnt != vlat[i] - 1) begin errors++; $display("FAIL inc%0d_busy_cycles got %0d exp %0d", i, bcnt, vlat[i] - 1); end
         checks++; if (s !== vs[i]) begin errors++; $display("FAIL inc%0d_s got %h exp %h", i, s, vs[i]); end
         checks++; if (co !== vco[i]) begin errors++; $display("FAIL inc%0d_co got %b exp %b", i, co, vco[i]); end
         checks++; if ((busy !== 1'b0) || (slice_a !== 2'b0)) begin errors++; $display("FAIL inc%0d_done_state busy=%b slice_a=%b exp 0/00", i, busy, slice_a); end
         tick();
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL inc%0d_done_pulse got %b exp 0", i, done); end
         checks++; if ((s !== vs[i]) || (co !== vco[i])) begin errors++; $display("FAIL inc%0d_idle_hold got %h/%b exp %h/%b", i, s, co, vs[i], vco[i]); end
      end
   endtask

   task automatic test_start_ignored();
      int done_cnt = 0;
      logic [7:0] s_seen = 8'hxx;
      start_op(8'h0F, 1'b1);
      tick();
      start = 1'b1;
      a     = 8'hFF;
      ci    = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (done === 1'b1) begin
            done_cnt++;
            s_seen = s;
         end
         tick();
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count got %0d exp 1", done_cnt); end
      checks++; if (s_seen !== 8'h10) begin errors++; $display("FAIL ignore_s got %h exp 10", s_seen); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL ignore_co got %b exp 0", co); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bcnt;
      int stray = 0;
      start_op(8'hFF, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy); end
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL midrst_s got %h exp 00", s); end
      checks++; if (co !== 1'b0) begin errors++; $display("FAIL midrst_co got %b exp 0", co); end
      checks++; if (slice_a !== 2'b00) begin errors++; $display("FAIL midrst_slice_a got %b exp 00", slice_a); end
      for (int k = 0; k < 6; k++) begin
         if ((done === 1'b1) || (busy === 1'b1)) stray++;
         tick();
      end
      checks++; if (stray != 0) begin errors++; $display("FAIL midrst_stray_activity got %0d exp 0", stray); end
      start_op(8'h5A, 1'b0);
      wait_done(lat, bcnt);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL midrst_timeout done=%b", done); end
      checks++; if ((s !== 8'h5A) || (co !== 1'b0)) begin errors++; $display("FAIL midrst_result got %h/%b exp 5a/0", s, co); end
      tick();
   endtask

   task automatic test_back_to_back();
      int lat, bcnt;
      start = 1'b1;
      a     = 8'h01;
      ci    = 1'b1;
      tick();
      a = 8'h03;
      wait_done(lat, bcnt);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_timeout done=%b", done); end
      checks++; if ((s !== 8'h02) || (co !== 1'b0)) begin errors++; $display("FAIL b2b_first got %h/%b exp 02/0", s, co); end
      tick();
      start = 1'b0;
      checks++; if ((busy !== 1'b1) || (done !== 1'b0)) begin errors++; $display("FAIL b2b_restart busy=%b done=%b exp 1/0", busy, done); end
      checks++; if ((slice_a !== 2'b11) || (slice_ci !== 1'b1)) begin errors++; $display("FAIL b2b_restart_slice got %b/%b exp 11/1", slice_a, slice_ci); end
      wait_done(lat, bcnt);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_second_timeout done=%b", done); end
      checks++; if ((s !== 8'h04) || (co !== 1'b0)) begin errors++; $display("FAIL b2b_second got %h/%b exp 04/0", s, co); end
      tick();
   endtask

   initial begin
      test_reset();
      test_increment();
      test_start_ignored();
      test_reset_mid_run();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_inc_controller.md
Name: serial_inc_controller

Overview:
Sequences a single shared 2-bit increment slice over an N-bit operand, two bits per clock, with the carry held in a flip-flop.
- Serial, area-saving alternative to the fully unrolled N-bit incrementer chain.
- The slice is instantiated outside this block. The controller drives its inputs and samples its combinational outputs in the same cycle.
- Start/done handshake toward the requester.

Parameters:
N, 8, operand width in bits; must be even and >= 2 (elaboration error otherwise)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE and DONE
a  input  N  operand; captured on accepted start
ci  input  1  carry-in; captured on accepted start
slice_a  output  2  operand bits presented to shared slice
slice_ci  output  1  carry presented to shared slice
slice_s  input  2  slice sum (combinational from slice_a/slice_ci)
slice_co  input  1  slice carry-out
busy  output  1  high in RUN
done  output  1  one-cycle pulse in DONE
s  output  N  result; valid from done until next accepted start
co  output  1  final carry-out; valid with s

Behaviour:
- States: IDLE, RUN, DONE. Counter idx counts 0..N/2-1.
- Reset (rst=1 at edge): state=IDLE; idx=0; carry flop=0; operand shift reg=0; s=0; co=0; busy=0; done=0. Reset has priority over all other events, including mid-RUN; the partial result is discarded.
- IDLE: start=1 -> load shift reg=a, carry=ci, idx=0, go RUN. start=0 -> stay.
- RUN, per cycle:
  - slice_a = shift[1:0]; slice_ci = carry.
  - At the edge: shift >>= 2; result reg = {slice_s, result[N-1:2]}; carry = slice_co; idx++.
  - When idx = N/2-1 at the edge: co = slice_co, s = final result, go DONE.
- Latency: start accepted at edge k -> RUN occupies cycles k+1..k+N/2 -> done=1 in cycle k+N/2+1.
- DONE: done=1 and busy=0 for exactly one cycle.
  - start=1 in DONE -> accepted as in IDLE and go RUN (back-to-back; no idle gap required).
  - Otherwise go IDLE.
- start in RUN is ignored (not queued).
- s/co hold their value in IDLE. s/co are not updated during RUN; the result is built in an internal register and transferred on the last RUN edge.
- Outside RUN: slice_a=0 and slice_ci=0.
- Arithmetic: {co,s} = a + ci, modulo 2^(N+1). Wrap case: a=all-ones, ci=1 -> s=0, co=1.

Optional Feature:
Macro EARLY_EXIT_EN.
- Defined: in RUN, if slice_co=0 at an edge before the last slice, the controller finishes immediately.
  - s = {remaining unprocessed shift bits, slice_s, result bits so far}, placed in correct bit order.
  - co = 0; go DONE next cycle.
  - Latency becomes 1 + (index of first slice with carry-out 0) + 1 cycles, minimum 2.
- Not defined: always exactly N/2 RUN cycles.
- Both builds produce identical s/co for every input.

Test Plan:
- N=8, a=0x0F, ci=1 -> after 4 RUN cycles, done pulse, s=0x10, co=0; busy high exactly 4 cycles.
- N=8, a=0xFF, ci=1 -> s=0x00, co=1. With a=0x5A, ci=0 -> s=0x5A, co=0.
- N=8, start pulsed during RUN cycle 2 with a different operand -> ignored; result matches the first operand; done pulses once.
- N=8, rst=1 in RUN cycle 3 -> next cycle IDLE with s=0, co=0, busy=0; a new start completes correctly.
- Back-to-back: start held high through DONE, a=0x01 then 0x03, ci=1 -> results 0x02 then 0x04; second RUN begins the cycle after done.
- EARLY_EXIT_EN, N=8, a=0x00, ci=1 -> done 2 cycles after start, s=0x01, co=0. Without the macro -> done after 5 cycles, same result.
